// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one outstanding imem request at a
// time and presents the returned word (or a NOP bubble) to decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic [6:0]  last_opcode,
    output logic [2:0]  last_funct3
);

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] pend_inst_r;
    logic [31:0] pend_pc_r;

    logic [31:0] redir_pc_s;
    logic [31:0] pc_inc_s;
    logic        load_s;
    logic [31:0] load_inst_s;
    logic [31:0] load_pc_s;

    assign redir_pc_s = redirect_pc & 32'hFFFF_FFFC;
    assign pc_inc_s   = pc_r + 32'd4;

    // Decide whether the IR takes a new word this cycle and where it comes from
    always_comb begin
        load_s      = 1'b0;
        load_inst_s = imem_rdata;
        load_pc_s   = pc_r;
        if (redirect_valid || stall) begin
            load_s = 1'b0;
        end else if (state_r == ST_HOLD) begin
            load_s      = 1'b1;
            load_inst_s = pend_inst_r;
            load_pc_s   = pend_pc_r;
        end else if (state_r == ST_WAIT && imem_rvalid) begin
            load_s = 1'b1;
        end else begin
            load_s = 1'b0;
        end
    end

    // Fetch FSM: PC, request strobe/address and the pending buffer used while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_BOOT;
            pc_r        <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= 32'h0000_0000;
            pend_inst_r <= NOP_INST;
            pend_pc_r   <= 32'h0000_0000;
        end else if (redirect_valid) begin
            pc_r        <= redir_pc_s;
            pend_inst_r <= NOP_INST;
            pend_pc_r   <= 32'h0000_0000;
            // A request still in flight must have its response swallowed first
            if (state_r == ST_WAIT && !imem_rvalid) begin
                state_r  <= ST_DRAIN;
                imem_req <= 1'b0;
            end else begin
                state_r   <= ST_REQ;
                imem_req  <= 1'b1;
                imem_addr <= redir_pc_s;
            end
        end else begin
            imem_req <= 1'b0;
            case (state_r)
                ST_BOOT: begin
                    state_r   <= ST_REQ;
                    imem_req  <= 1'b1;
                    imem_addr <= pc_r;
                end
                ST_REQ: begin
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        pc_r <= pc_inc_s;
                        if (stall) begin
                            pend_inst_r <= imem_rdata;
                            pend_pc_r   <= pc_r;
                            state_r     <= ST_HOLD;
                        end else begin
                            state_r   <= ST_REQ;
                            imem_req  <= 1'b1;
                            imem_addr <= pc_inc_s;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        state_r   <= ST_REQ;
                        imem_req  <= 1'b1;
                        imem_addr <= pc_r;
                    end
                end
                ST_DRAIN: begin
                    if (imem_rvalid) begin
                        state_r   <= ST_REQ;
                        imem_req  <= 1'b1;
                        imem_addr <= pc_r;
                    end
                end
                default: begin
                    state_r <= ST_BOOT;
                    pc_r    <= RESET_PC;
                end
            endcase
        end
    end

    // Instruction register: load, freeze under stall, or fall back to a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid <= 1'b0;
            if_pc    <= 32'h0000_0000;
            if_inst  <= NOP_INST;
        end else if (redirect_valid) begin
            if_valid <= 1'b0;
            if_inst  <= NOP_INST;
        end else if (load_s) begin
            if_valid <= 1'b1;
            if_pc    <= load_pc_s;
            if_inst  <= load_inst_s;
        end else if (!stall) begin
            if_valid <= 1'b0;
            if_inst  <= NOP_INST;
        end
    end

    assign last_opcode = if_inst[6:0];
    assign last_funct3 = if_inst[14:12];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: table of fetch transactions plus directed redirect/reset
// sequences; delivered instructions are checked against a scoreboard queue.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic [6:0]  last_opcode;
    logic [2:0]  last_funct3;

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .last_opcode    (last_opcode),
        .last_funct3    (last_funct3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        int          lat;
        int          stall_cyc;
        logic [31:0] exp_addr;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    logic        stall_e = 1'b0;
    logic        redir_e = 1'b0;
    logic        rst_e = 1'b0;
    logic        prev_valid = 1'b0;
    logic [31:0] prev_pc = 32'h0;
    logic [31:0] prev_inst = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output logic [31:0] addr);
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (imem_req) got = 1'b1;
            else tick();
        end
        if (got) begin
            addr = imem_addr;
        end else begin
            addr = 32'hXXXX_XXXX;
            n_checks++;
            n_fail++;
            $display("FAIL req_timeout: actual no imem_req required imem_req within 20 cycles");
        end
    endtask

    // Called at the sample point of the cycle in which the request is visible.
    task automatic respond(input logic [31:0] pc, input logic [31:0] data,
                           input int lat, input int stall_cyc);
        if (stall_cyc > 0) stall = 1'b1;
        repeat (lat) tick();
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        sb.push_back('{pc, data});
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (stall_cyc > 0) begin
            repeat (stall_cyc) begin
                chk("no_req_in_hold", {31'd0, imem_req}, 32'd0);
                tick();
            end
            stall = 1'b0;
            tick();
        end
    endtask

    task automatic bubble_chk(input string tag);
        chk({tag, "_valid"}, {31'd0, if_valid}, 32'd0);
        chk({tag, "_inst"}, if_inst, NOP);
        chk({tag, "_opcode"}, {25'd0, last_opcode}, 32'h13);
        chk({tag, "_funct3"}, {29'd0, last_funct3}, 32'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            stall_e = stall;
            redir_e = redirect_valid;
            rst_e   = rst_n;
        end
    end

    // Output monitor: every cycle is a redirect bubble, a stall hold, a new
    // instruction (popped from the scoreboard) or a plain bubble.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rst_e) begin
                if (redir_e) begin
                    bubble_chk("redir_bubble");
                end else if (stall_e) begin
                    chk("hold_valid", {31'd0, if_valid}, {31'd0, prev_valid});
                    chk("hold_pc", if_pc, prev_pc);
                    chk("hold_inst", if_inst, prev_inst);
                end else if (if_valid) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_inst: actual %h@%h required no instruction", if_inst, if_pc);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_pc", if_pc, e.pc);
                        chk("sb_inst", if_inst, e.inst);
                        chk("sb_opcode", {25'd0, last_opcode}, {25'd0, e.inst[6:0]});
                        chk("sb_funct3", {29'd0, last_funct3}, {29'd0, e.inst[14:12]});
                    end
                end else begin
                    bubble_chk("bubble");
                end
            end
            prev_valid = if_valid;
            prev_pc    = if_pc;
            prev_inst  = if_inst;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual simulation still running required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs[5];
        logic [31:0] a;

        vecs[0] = '{32'h0050_0093, 1, 0, 32'h0000_0000};
        vecs[1] = '{32'h00C0_0113, 1, 2, 32'h0000_0004};
        vecs[2] = '{32'h0020_81B3, 3, 0, 32'h0000_0008};
        vecs[3] = '{32'hFFF0_0213, 2, 1, 32'h0000_000C};
        vecs[4] = '{32'h4020_8233, 1, 0, 32'h0000_0010};

        // Reset values, BOOT cycle, first request
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_inst", if_inst, NOP);
        chk("rst_opcode", {25'd0, last_opcode}, 32'h13);
        chk("rst_funct3", {29'd0, last_funct3}, 32'd0);
        rst_n = 1'b1;
        chk("boot_no_req", {31'd0, imem_req}, 32'd0);
        tick();
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'd0);
        chk("first_valid", {31'd0, if_valid}, 32'd0);
        chk("first_opcode", {25'd0, last_opcode}, 32'h13);

        // Straight-line fetches with varied latency and stalls
        for (int i = 0; i < 5; i++) begin
            wait_req(a);
            chk("tbl_req_addr", a, vecs[i].exp_addr);
            respond(vecs[i].exp_addr, vecs[i].rdata, vecs[i].lat, vecs[i].stall_cyc);
        end

        // Redirect while waiting: stale response must be drained
        wait_req(a);
        chk("pre_drain_addr", a, 32'h0000_0014);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        chk("drain_no_req0", {31'd0, imem_req}, 32'd0);
        tick();
        chk("drain_no_req1", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        chk("drain_valid", {31'd0, if_valid}, 32'd0);
        wait_req(a);
        chk("redir_addr", a, 32'h0000_0100);
        respond(32'h0000_0100, 32'h0010_0093, 1, 0);

        // Redirect and response in the same cycle: response dropped
        wait_req(a);
        chk("pre_same_addr", a, 32'h0000_0104);
        tick();
        imem_rvalid    = 1'b1;
        imem_rdata     = 32'h1111_1111;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        imem_rvalid    = 1'b0;
        redirect_valid = 1'b0;
        wait_req(a);
        chk("same_cycle_addr", a, 32'h0000_0200);
        respond(32'h0000_0200, 32'h0020_8663, 1, 0);

        // Redirect with misaligned target, then PC wrap-around
        wait_req(a);
        chk("pre_wrap_addr", a, 32'h0000_0204);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        wait_req(a);
        chk("top_addr", a, 32'hFFFF_FFFC);
        respond(32'hFFFF_FFFC, 32'h3401_1073, 1, 0);
        wait_req(a);
        chk("wrap_addr", a, 32'h0000_0000);

        // Asynchronous reset in the middle of a wait; late response ignored
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_req", {31'd0, imem_req}, 32'd0);
        chk("arst_addr", imem_addr, 32'd0);
        chk("arst_valid", {31'd0, if_valid}, 32'd0);
        chk("arst_pc", if_pc, 32'd0);
        chk("arst_inst", if_inst, NOP);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        tick();
        imem_rvalid = 1'b0;
        chk("rerst_valid", {31'd0, if_valid}, 32'd0);
        wait_req(a);
        chk("rerst_addr", a, 32'h0000_0000);
        respond(32'h0000_0000, 32'h00A0_0513, 1, 0);

        repeat (2) tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
